// File: rtl/bitplane_dma.sv
// Bitplane fetch sequencer: walks the data-fetch window each display line,
// issues one bus slot per enabled plane with the pointer address and the
// matching BPLxDAT destination, and applies the odd/even modulos at line end.
module bitplane_dma #(
    parameter int LORES_UNIT = 8,
    parameter int HIRES_UNIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cck,
    input  logic [8:0]  hcnt,
    input  logic        eol,
    input  logic        dmaen,
    input  logic        vwin,
    input  logic [7:0]  reg_address_in,
    input  logic [15:0] data_in,
    output logic        dma,
    output logic [19:0] address_out,
    output logic [7:0]  reg_address_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FETCH = 2'd2,
        S_MOD   = 2'd3
    } state_t;

    // Register addresses are [8:1] of the byte address.
    localparam logic [7:0] A_DDFSTRT = 8'h49;
    localparam logic [7:0] A_DDFSTOP = 8'h4A;
    localparam logic [7:0] A_BPLCON0 = 8'h80;
    localparam logic [7:0] A_BPL1MOD = 8'h84;
    localparam logic [7:0] A_BPL2MOD = 8'h85;
    localparam logic [7:0] A_BPL1PTH = 8'h70;
    localparam logic [7:0] A_BPL1DAT = 8'h88;

    state_t      r_state;
    logic [5:0]  r_ddfstrt;      // DDFSTRT[7:2]
    logic [5:0]  r_ddfstop;      // DDFSTOP[7:2]
    logic        r_hires;
    logic [2:0]  r_bpu;
    logic [14:0] r_mod1;         // modulo in words (byte value [15:1])
    logic [14:0] r_mod2;
    logic [5:0]  r_ustart;       // hcnt[7:2] at the start of the current unit
    logic [19:0] r_ptr [6];
    logic        r_dma;
    logic [19:0] r_address_out;
    logic [7:0]  r_reg_address_out;

    logic [2:0]  w_off;
    logic        w_boundary;
    logic [2:0]  w_plane;
    logic [2:0]  w_np_raw;
    logic [2:0]  w_np;
    logic        w_plane_ok;
    logic        w_start_match;
    logic        w_window_done;
    logic        w_fetch_go;
    logic [19:0] w_ptr_sel;
    logic [19:0] w_mod1_ext;
    logic [19:0] w_mod2_ext;
    logic [19:0] w_ptr_dma [6];
    logic [19:0] w_ptr_nxt [6];
    logic        w_unused;

    assign w_unused   = data_in[0];
    assign w_mod1_ext = {{5{r_mod1[14]}}, r_mod1};
    assign w_mod2_ext = {{5{r_mod2[14]}}, r_mod2};

    // Slot position inside the fetch unit and the plane that owns it.
    always_comb begin
        w_off      = hcnt[2:0] & (r_hires ? 3'(HIRES_UNIT - 1) : 3'(LORES_UNIT - 1));
        w_boundary = (w_off == 3'd0);
        w_plane    = 3'd0;
        if (r_hires) begin
            case (w_off[1:0])
                2'd0:    w_plane = 3'd4;
                2'd1:    w_plane = 3'd2;
                2'd2:    w_plane = 3'd3;
                2'd3:    w_plane = 3'd1;
                default: w_plane = 3'd0;
            endcase
        end else begin
            case (w_off)
                3'd1:    w_plane = 3'd4;
                3'd2:    w_plane = 3'd6;
                3'd3:    w_plane = 3'd2;
                3'd5:    w_plane = 3'd3;
                3'd6:    w_plane = 3'd5;
                3'd7:    w_plane = 3'd1;
                default: w_plane = 3'd0;
            endcase
        end
    end

    // Effective plane count, window compares and the fetch decision.
    always_comb begin
        w_np_raw      = (r_bpu == 3'd7) ? 3'd4 : r_bpu;
        w_np          = (r_hires && (w_np_raw > 3'd4)) ? 3'd4 : w_np_raw;
        w_plane_ok    = (w_plane != 3'd0) && (w_plane <= w_np);
        w_start_match = r_hires ? (hcnt[7:2] == r_ddfstrt) : (hcnt[7:3] == r_ddfstrt[5:1]);
        // The unit that started at or beyond ddfstop was the last one.
        w_window_done = r_hires ? (r_ustart >= r_ddfstop) : (r_ustart[5:1] >= r_ddfstop[5:1]);
        w_fetch_go    = cck && dmaen && !eol && w_plane_ok &&
                        (((r_state == S_WAIT) && w_boundary && w_start_match) ||
                         ((r_state == S_FETCH) && !(w_boundary && w_window_done)));
        w_ptr_sel     = 20'd0;
        for (int i = 0; i < 6; i++) begin
            if (w_plane == 3'(i + 1)) begin
                w_ptr_sel = r_ptr[i];
            end else begin
                w_ptr_sel = w_ptr_sel;
            end
        end
    end

    // Next pointer values: DMA increment or modulo, then CPU half-writes override
    // using the pre-increment value of the untouched half.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            if (w_fetch_go && (w_plane == 3'(i + 1))) begin
                w_ptr_dma[i] = r_ptr[i] + 20'd1;
            end else if (r_state == S_MOD) begin
                w_ptr_dma[i] = r_ptr[i] + (((i % 2) == 0) ? w_mod1_ext : w_mod2_ext);
            end else begin
                w_ptr_dma[i] = r_ptr[i];
            end
            if (reg_address_in == (A_BPL1PTH + 8'(2 * i))) begin
                w_ptr_nxt[i] = {data_in[4:0], r_ptr[i][14:0]};
            end else if (reg_address_in == (A_BPL1PTH + 8'(2 * i + 1))) begin
                w_ptr_nxt[i] = {r_ptr[i][19:15], data_in[15:1]};
            end else begin
                w_ptr_nxt[i] = w_ptr_dma[i];
            end
        end
    end

    // Bitplane pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 6; i++) begin
                r_ptr[i] <= 20'd0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                r_ptr[i] <= w_ptr_nxt[i];
            end
        end
    end

    // CPU-visible control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ddfstrt <= 6'd0;
            r_ddfstop <= 6'd0;
            r_hires   <= 1'b0;
            r_bpu     <= 3'd0;
            r_mod1    <= 15'd0;
            r_mod2    <= 15'd0;
        end else begin
            case (reg_address_in)
                A_DDFSTRT: r_ddfstrt <= data_in[7:2];
                A_DDFSTOP: r_ddfstop <= data_in[7:2];
                A_BPLCON0: begin
                    r_hires <= data_in[15];
                    r_bpu   <= data_in[14:12];
                end
                A_BPL1MOD: r_mod1 <= data_in[15:1];
                A_BPL2MOD: r_mod2 <= data_in[15:1];
                default: begin
                end
            endcase
        end
    end

    // Line sequencer with registered slot outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_ustart          <= 6'd0;
            r_dma             <= 1'b0;
            r_address_out     <= 20'd0;
            r_reg_address_out <= 8'hFF;
        end else begin
            if (cck) begin
                if (w_fetch_go) begin
                    r_dma             <= 1'b1;
                    r_address_out     <= w_ptr_sel;
                    r_reg_address_out <= A_BPL1DAT + {5'd0, w_plane - 3'd1};
                end else begin
                    r_dma             <= 1'b0;
                    r_reg_address_out <= 8'hFF;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (cck && (hcnt == 9'd0) && dmaen && vwin && (w_np != 3'd0)) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cck) begin
                        if (eol) begin
                            r_state <= S_MOD;
                        end else if (!dmaen) begin
                            r_state <= S_IDLE;
                        end else if (w_boundary && w_start_match) begin
                            r_state  <= S_FETCH;
                            r_ustart <= hcnt[7:2];
                        end
                    end
                end
                S_FETCH: begin
                    if (cck) begin
                        if (eol || !dmaen) begin
                            r_state <= S_MOD;
                        end else if (w_boundary) begin
                            if (w_window_done) begin
                                r_state <= S_MOD;
                            end else begin
                                r_ustart <= hcnt[7:2];
                            end
                        end
                    end
                end
                S_MOD:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dma             = r_dma;
    assign address_out     = r_address_out;
    assign reg_address_out = r_reg_address_out;

endmodule

// File: tb/tb_bitplane_dma.sv
// Bench for bitplane_dma: directed display lines checked every cycle against a
// line-level model of the fetch window, plus hand-computed end-of-test values.
module tb_bitplane_dma;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cck;
    logic [8:0]  hcnt;
    logic        eol;
    logic        dmaen;
    logic        vwin;
    logic [7:0]  reg_address_in;
    logic [15:0] data_in;
    logic        dma;
    logic [19:0] address_out;
    logic [7:0]  reg_address_out;

    always #5 clk = ~clk;

    bitplane_dma dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cck             (cck),
        .hcnt            (hcnt),
        .eol             (eol),
        .dmaen           (dmaen),
        .vwin            (vwin),
        .reg_address_in  (reg_address_in),
        .data_in         (data_in),
        .dma             (dma),
        .address_out     (address_out),
        .reg_address_out (reg_address_out)
    );

    int total = 0;
    int bad = 0;
    int nprint = 0;

    // model state
    logic [19:0] m_ptr [6];
    logic [19:0] m_pre [6];
    int          m_strt, m_stop, m_bpu;
    bit          m_hires;
    logic [14:0] m_mod1, m_mod2;
    bit          l_active, l_entered, l_dead;
    int          lmap [8] = '{0, 4, 6, 2, 0, 3, 5, 1};
    int          hmap [4] = '{4, 2, 3, 1};

    logic        exp_dma = 1'b0;
    logic [7:0]  exp_reg = 8'hFF;
    logic [19:0] exp_addr = 20'd0;
    bit          chk_en = 1'b0;

    // line control
    int          lcount;
    logic [7:0]  first_reg;
    int          drop_h = -1;
    int          rst_h = -1;
    int          wr_n = 0;
    int          wr_h [4];
    logic [7:0]  wr_a [4];
    logic [15:0] wr_d [4];
    bit          line_dmaen = 1'b1;
    bit          line_vwin = 1'b1;

    task automatic report(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            if (nprint < 40) $display("FAIL %s actual=%0h required=%0h", name, act, req);
            nprint++;
        end
    endtask

    // Per-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            report("dma", {31'd0, dma}, {31'd0, exp_dma});
            report("reg_address_out", {24'd0, reg_address_out}, {24'd0, exp_reg});
            if (exp_dma) report("address_out", {12'd0, address_out}, {12'd0, exp_addr});
        end
    end

    function automatic int np_of();
        int n;
        n = (m_bpu == 7) ? 4 : m_bpu;
        if (m_hires && n > 4) n = 4;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_ptr[i] = 20'd0;
        m_strt = 0; m_stop = 0; m_bpu = 0; m_hires = 1'b0;
        m_mod1 = 15'd0; m_mod2 = 15'd0;
        l_active = 1'b0; l_entered = 1'b0; l_dead = 1'b0;
        exp_dma = 1'b0; exp_reg = 8'hFF; exp_addr = 20'd0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [15:0] d);
        case (a)
            8'h49: m_strt = int'(d & 16'h00FC);
            8'h4A: m_stop = int'(d & 16'h00FC);
            8'h80: begin m_hires = d[15]; m_bpu = int'(d[14:12]); end
            8'h84: m_mod1 = d[15:1];
            8'h85: m_mod2 = d[15:1];
            default: ;
        endcase
        for (int i = 0; i < 6; i++) begin
            if (a == 8'h70 + 8'(2 * i)) m_ptr[i] = {d[4:0], m_pre[i][14:0]};
            if (a == 8'h71 + 8'(2 * i)) m_ptr[i] = {m_pre[i][19:15], d[15:1]};
        end
    endtask

    // One colour-clock slot: which plane (if any) the window gives this slot.
    task automatic model_slot(input int h);
        int us, u, off, su, eu, p, np;
        np  = np_of();
        us  = m_hires ? 4 : 8;
        u   = h / us;
        off = h % us;
        su  = m_strt / us;
        eu  = m_stop / us;
        if (eu < su) eu = su;
        if (h == 0) begin
            l_active = dmaen && vwin && (np != 0);
            l_entered = 1'b0;
            l_dead = 1'b0;
        end
        exp_dma = 1'b0;
        exp_reg = 8'hFF;
        if (l_active && !l_dead) begin
            if (!dmaen) begin
                l_dead = 1'b1;
            end else if (h > 0 && u >= su && u <= eu) begin
                l_entered = 1'b1;
                p = m_hires ? hmap[off] : lmap[off];
                if (p != 0 && p <= np) begin
                    exp_dma  = 1'b1;
                    exp_reg  = 8'h88 + 8'(p - 1);
                    exp_addr = m_ptr[p - 1];
                    m_ptr[p - 1] = m_ptr[p - 1] + 20'd1;
                end
            end
        end
    endtask

    task automatic model_eol();
        if (l_active && (l_entered || !l_dead)) begin
            for (int i = 0; i < 6; i++)
                m_ptr[i] = m_ptr[i] + (((i % 2) == 0) ? {{5{m_mod1[14]}}, m_mod1}
                                                      : {{5{m_mod2[14]}}, m_mod2});
        end
        l_active = 1'b0;
    endtask

    task automatic tick(input bit c, input int h, input logic [7:0] a, input logic [15:0] d);
        cck = c;
        hcnt = 9'(h);
        eol = c && (h == 226);
        reg_address_in = a;
        data_in = d;
        @(posedge clk);
        #1;
        m_pre = m_ptr;
        if (c) begin
            model_slot(h);
            if (dma) begin
                lcount++;
                if (lcount == 1) first_reg = reg_address_out;
            end
        end
        model_write(a, d);
        if (c && h == 226) model_eol();
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [15:0] d);
        tick(1'b0, 300, a, d);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        report("rst_dma", {31'd0, dma}, 32'd0);
        report("rst_reg", {24'd0, reg_address_out}, 32'h000000FF);
        report("rst_addr", {12'd0, address_out}, 32'd0);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic run_line();
        logic [7:0]  a;
        logic [15:0] d;
        lcount = 0;
        first_reg = 8'hFF;
        for (int h = 0; h <= 226; h++) begin
            a = 8'h00;
            d = 16'h0000;
            if (h == rst_h) do_reset();
            dmaen = line_dmaen && !(drop_h >= 0 && h >= drop_h);
            vwin = line_vwin;
            for (int k = 0; k < wr_n; k++) begin
                if (wr_h[k] == h) begin
                    a = wr_a[k];
                    d = wr_d[k];
                end
            end
            tick(1'b1, h, a, d);
            tick(1'b0, h, 8'h00, 16'h0000);
        end
        for (int i = 0; i < 6; i++) report("ptr_line_end", {12'd0, dut.r_ptr[i]}, {12'd0, m_ptr[i]});
        drop_h = -1;
        rst_h = -1;
        wr_n = 0;
        dmaen = line_dmaen;
    endtask

    initial begin
        reset_n = 1'b0; cck = 1'b0; hcnt = 9'd0; eol = 1'b0;
        dmaen = 1'b0; vwin = 1'b0; reg_address_in = 8'h00; data_in = 16'h0000;
        model_reset();
        for (int i = 0; i < 6; i++) m_pre[i] = 20'd0;
        #12;
        report("reset_dma", {31'd0, dma}, 32'd0);
        report("reset_reg", {24'd0, reg_address_out}, 32'h000000FF);
        report("reset_addr", {12'd0, address_out}, 32'd0);
        #11 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Lores, one plane, full window.
        cpu_wr(8'h49, 16'h0038); cpu_wr(8'h4A, 16'h00D0); cpu_wr(8'h80, 16'h1000);
        cpu_wr(8'h84, 16'h0000); cpu_wr(8'h85, 16'h0000);
        cpu_wr(8'h70, 16'h0001); cpu_wr(8'h71, 16'h0000);
        run_line();
        report("t1_count", lcount, 32'd20);
        report("t1_reg", {24'd0, first_reg}, 32'h88);
        report("t1_ptr1", {12'd0, dut.r_ptr[0]}, 32'h08014);

        // Lores, six planes, +/- modulos.
        cpu_wr(8'h84, 16'h0028); cpu_wr(8'h85, 16'hFFD8); cpu_wr(8'h80, 16'h6000);
        for (int i = 0; i < 6; i++) begin
            cpu_wr(8'h70 + 8'(2 * i), 16'(i + 1));
            cpu_wr(8'h71 + 8'(2 * i), 16'h0000);
        end
        run_line();
        report("t2_count", lcount, 32'd120);
        report("t2_first_reg", {24'd0, first_reg}, 32'h8B);
        report("t2_ptr1", {12'd0, dut.r_ptr[0]}, 32'h08028);
        report("t2_ptr2", {12'd0, dut.r_ptr[1]}, 32'h10000);
        report("t2_ptr5", {12'd0, dut.r_ptr[4]}, 32'h28028);
        report("t2_ptr6", {12'd0, dut.r_ptr[5]}, 32'h30000);

        // Hires, bpu=6 capped to four planes.
        cpu_wr(8'h80, 16'hE000); cpu_wr(8'h49, 16'h003C); cpu_wr(8'h4A, 16'h00D4);
        cpu_wr(8'h84, 16'h0000); cpu_wr(8'h85, 16'h0000);
        run_line();
        report("t3_count", lcount, 32'd156);
        report("t3_ptr1", {12'd0, dut.r_ptr[0]}, 32'h0804F);
        report("t3_ptr4", {12'd0, dut.r_ptr[3]}, 32'h20027);
        report("t3_ptr5", {12'd0, dut.r_ptr[4]}, 32'h28028);
        report("t3_ptr6", {12'd0, dut.r_ptr[5]}, 32'h30000);

        // vwin=0, then bpu=0: nothing fetched.
        cpu_wr(8'h80, 16'h1000); cpu_wr(8'h49, 16'h0038); cpu_wr(8'h4A, 16'h00D0);
        line_vwin = 1'b0;
        run_line();
        report("t4_vwin_count", lcount, 32'd0);
        line_vwin = 1'b1;
        cpu_wr(8'h80, 16'h0000);
        run_line();
        report("t4_bpu0_count", lcount, 32'd0);
        report("t4_ptr1", {12'd0, dut.r_ptr[0]}, 32'h0804F);

        // ddfstop < ddfstrt: one unit only.
        cpu_wr(8'h80, 16'h2000); cpu_wr(8'h49, 16'h0060); cpu_wr(8'h4A, 16'h0040);
        run_line();
        report("t5_count", lcount, 32'd2);
        report("t5_first_reg", {24'd0, first_reg}, 32'h89);

        // CPU low-half write colliding with the P1 increment.
        cpu_wr(8'h80, 16'h1000); cpu_wr(8'h49, 16'h0038); cpu_wr(8'h4A, 16'h0038);
        cpu_wr(8'h70, 16'h0000); cpu_wr(8'h71, 16'h0200);
        wr_n = 1; wr_h[0] = 'h3F; wr_a[0] = 8'h71; wr_d[0] = 16'h0200;
        run_line();
        report("t6_count", lcount, 32'd1);
        report("t6_ptr1", {12'd0, dut.r_ptr[0]}, 32'h00100);

        // Pointer wrap.
        cpu_wr(8'h70, 16'h001F); cpu_wr(8'h71, 16'hFFFE);
        run_line();
        report("t7_count", lcount, 32'd1);
        report("t7_ptr1", {12'd0, dut.r_ptr[0]}, 32'h00000);

        // dmaen dropped mid-window: modulo still applied once.
        cpu_wr(8'h4A, 16'h00D0); cpu_wr(8'h71, 16'h2000); cpu_wr(8'h84, 16'h0010);
        drop_h = 'h50;
        run_line();
        report("t8_count", lcount, 32'd3);
        report("t8_ptr1", {12'd0, dut.r_ptr[0]}, 32'h0100B);

        // Reset mid-fetch, reprogram, idle until the next line start.
        cpu_wr(8'h84, 16'h0000); cpu_wr(8'h71, 16'h2000);
        rst_h = 'h60;
        wr_n = 4;
        wr_h[0] = 'h70; wr_a[0] = 8'h80; wr_d[0] = 16'h1000;
        wr_h[1] = 'h72; wr_a[1] = 8'h49; wr_d[1] = 16'h0038;
        wr_h[2] = 'h74; wr_a[2] = 8'h4A; wr_d[2] = 16'h0038;
        wr_h[3] = 'h76; wr_a[3] = 8'h71; wr_d[3] = 16'h0100;
        run_line();
        report("t9_count", lcount, 32'd5);
        run_line();
        report("t9_next_count", lcount, 32'd1);
        report("t9_ptr1", {12'd0, dut.r_ptr[0]}, 32'h00081);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
